// File: rtl/hog_svm_acc.sv
// hog_svm_acc: linear-SVM scoring of HOG block descriptors.
// Each block is four cells of 9 bins. Every bin is multiplied by a weight read from an
// external memory, and NBLK consecutive blocks are accumulated into one window score.
// Optional macro HOG_SVM_SAT_EN makes the accumulator and the bias add saturate.
// Without that macro, both operations wrap in two's complement.
module hog_svm_acc #(
   parameter int unsigned FEA_I = 4,
   parameter int unsigned FEA_F = 28,
   parameter int unsigned W_W   = 16,
   parameter int unsigned W_F   = 12,
   parameter int unsigned BID_W = 13,
   parameter int unsigned NBLK  = 105,
   parameter int unsigned WA_W  = 10,
   parameter int unsigned ACC_W = 56
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_valid,
   input  logic [BID_W-1:0]                bid,
   input  logic [9*(FEA_I+FEA_F)-1:0]      fea_a,
   input  logic [9*(FEA_I+FEA_F)-1:0]      fea_b,
   input  logic [9*(FEA_I+FEA_F)-1:0]      fea_c,
   input  logic [9*(FEA_I+FEA_F)-1:0]      fea_d,
   input  logic signed [ACC_W-1:0]         bias,
   output logic                            w_rd,
   output logic [WA_W-1:0]                 w_addr,
   input  logic [4*W_W-1:0]                w_data,
   output logic                            busy,
   output logic                            overrun,
   output logic                            o_valid,
   output logic [BID_W-1:0]                o_bid,
   output logic signed [ACC_W-1:0]         score,
   output logic                            detect
);

   localparam int unsigned FEA_W  = FEA_I + FEA_F;
   localparam int unsigned ROW_W  = 9 * FEA_W;
   localparam int unsigned PROD_W = FEA_W + 1 + W_W;
   localparam int unsigned SUM_W  = PROD_W + 2;
   localparam int unsigned EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
   localparam int unsigned BC_W   = (NBLK > 1) ? $clog2(NBLK) : 1;
   localparam int unsigned K_W    = 4;

   // Reject parameter sets the datapath cannot represent.
   if (W_F >= W_W) begin : g_bad_wf
      $error("hog_svm_acc: W_F must be smaller than W_W");
   end
   if (WA_W < $clog2(NBLK * 9)) begin : g_bad_wa
      $error("hog_svm_acc: WA_W too narrow for NBLK*9 weight rows");
   end

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT} state_e;

   state_e                   state_q, state_d;
   logic [K_W-1:0]           k_q, k_d;
   logic [BC_W-1:0]          blk_cnt_q, blk_cnt_d;

   logic                     w_rd_q, w_rd_d;
   logic [WA_W-1:0]          w_addr_q, w_addr_d;
   logic                     busy_q, busy_d;
   logic                     overrun_q, overrun_d;
   logic                     o_valid_q, o_valid_d;
   logic [BID_W-1:0]         o_bid_q, o_bid_d;
   logic signed [ACC_W-1:0]  score_q, score_d;
   logic                     detect_q, detect_d;

   logic [ROW_W-1:0]         fea_q [4];
   logic [BID_W-1:0]         bid_q;
   logic                     dvld_q;
   logic [K_W-1:0]           dk_q;
   logic signed [PROD_W-1:0] prod_q [4];
   logic signed [PROD_W-1:0] prod_d [4];
   logic                     pvld_q;
   logic signed [SUM_W-1:0]  psum;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic                     accept;

   // Add a wide signed term to an ACC_W value (saturating or wrapping).
   function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [EXT_W-1:0] b);
`ifdef HOG_SVM_SAT_EN
      logic signed [EXT_W-1:0] r;
      r = EXT_W'(a) + b;
      if (r[EXT_W-1:ACC_W-1] != {(EXT_W-ACC_W+1){r[EXT_W-1]}}) begin
         return r[EXT_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
      return r[ACC_W-1:0];
`else
      return a + ACC_W'(b);
`endif
   endfunction

   assign accept = (state_q == S_IDLE) && i_valid;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         blk_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         blk_cnt_q <= blk_cnt_d;
      end
   end

   // FSM next state: 9 fetch cycles, 2 drain cycles, then the next block or the window score.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      blk_cnt_d = blk_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               state_d = S_FETCH;
               k_d     = '0;
            end
         end
         S_FETCH: begin
            if (k_q == K_W'(8)) begin
               state_d = S_DRAIN;
               k_d     = '0;
            end else begin
               k_d = k_q + K_W'(1);
            end
         end
         S_DRAIN: begin
            if (k_q == K_W'(1)) begin
               k_d = '0;
               if (blk_cnt_q == BC_W'(NBLK - 1)) begin
                  state_d = S_OUT;
               end else begin
                  blk_cnt_d = blk_cnt_q + BC_W'(1);
                  state_d   = S_IDLE;
               end
            end else begin
               k_d = k_q + K_W'(1);
            end
         end
         S_OUT: begin
            blk_cnt_d = '0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: the next values of the registered ports, derived from the next state.
   always_comb begin
      w_rd_d    = (state_d == S_FETCH);
      w_addr_d  = '0;
      if (w_rd_d) begin
         w_addr_d = WA_W'(blk_cnt_q) * WA_W'(9) + WA_W'(k_d);
      end
      busy_d    = (state_d != S_IDLE);
      overrun_d = overrun_q | (i_valid & (state_q != S_IDLE));
      o_valid_d = (state_d == S_OUT);
      o_bid_d   = o_bid_q;
      score_d   = score_q;
      detect_d  = detect_q;
      if (o_valid_d) begin
         o_bid_d  = bid_q;
         score_d  = acc_add(acc_d, EXT_W'(bias));
         detect_d = !score_d[ACC_W-1] && (score_d != '0);
      end
   end

   // Registered output ports.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_rd_q    <= 1'b0;
         w_addr_q  <= '0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         o_valid_q <= 1'b0;
         o_bid_q   <= '0;
         score_q   <= '0;
         detect_q  <= 1'b0;
      end else begin
         w_rd_q    <= w_rd_d;
         w_addr_q  <= w_addr_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
         o_valid_q <= o_valid_d;
         o_bid_q   <= o_bid_d;
         score_q   <= score_d;
         detect_q  <= detect_d;
      end
   end

   // Product stage: the bin selected by the returning row times its four cell weights; the sum feeds the accumulator.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         prod_d[i] = PROD_W'($signed({1'b0, fea_q[i][32'(dk_q) * FEA_W +: FEA_W]}))
                   * PROD_W'($signed(w_data[i * W_W +: W_W]));
      end
      psum = SUM_W'(prod_q[0]) + SUM_W'(prod_q[1]) + SUM_W'(prod_q[2]) + SUM_W'(prod_q[3]);
      acc_d = acc_q;
      if (accept && (blk_cnt_q == '0)) begin
         acc_d = '0;
      end else if (pvld_q) begin
         acc_d = acc_add(acc_q, EXT_W'(psum));
      end
   end

   // Datapath registers: descriptor latch, weight-return tracking, products and accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            fea_q[i]  <= '0;
            prod_q[i] <= '0;
         end
         bid_q  <= '0;
         dvld_q <= 1'b0;
         dk_q   <= '0;
         pvld_q <= 1'b0;
         acc_q  <= '0;
      end else begin
         if (accept) begin
            fea_q[0] <= fea_a;
            fea_q[1] <= fea_b;
            fea_q[2] <= fea_c;
            fea_q[3] <= fea_d;
            bid_q    <= bid;
         end
         dvld_q <= w_rd_q;
         dk_q   <= k_q;
         if (dvld_q) begin
            for (int i = 0; i < 4; i++) begin
               prod_q[i] <= prod_d[i];
            end
         end
         pvld_q <= dvld_q;
         acc_q  <= acc_d;
      end
   end

   assign w_rd    = w_rd_q;
   assign w_addr  = w_addr_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;
   assign o_valid = o_valid_q;
   assign o_bid   = o_bid_q;
   assign score   = score_q;
   assign detect  = detect_q;

endmodule

// File: tb/tb_hog_svm_acc.sv
// Scoreboard bench for hog_svm_acc (NBLK=2), with a 56-bit and a 48-bit accumulator instance in lockstep.
module tb_hog_svm_acc;

   localparam int unsigned FEA_W = 32;
   localparam int unsigned W_W   = 16;
   localparam int unsigned BID_W = 13;
   localparam int unsigned NBLK  = 2;
   localparam int unsigned WA_W  = 10;
   localparam int unsigned ACC_A = 56;
   localparam int unsigned ACC_B = 48;
`ifdef HOG_SVM_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     i_valid;
   logic [BID_W-1:0]         bid;
   logic [9*FEA_W-1:0]       fea_a, fea_b, fea_c, fea_d;
   logic signed [ACC_A-1:0]  bias;
   logic signed [ACC_B-1:0]  bias48;
   logic [4*W_W-1:0]         w_data;
   logic                     w_rd, busy, overrun, o_valid, detect;
   logic [WA_W-1:0]          w_addr;
   logic [BID_W-1:0]         o_bid;
   logic signed [ACC_A-1:0]  score;
   logic                     w_rd48, busy48, overrun48, o_valid48, detect48;
   logic [WA_W-1:0]          w_addr48;
   logic [BID_W-1:0]         o_bid48;
   logic signed [ACC_B-1:0]  score48;

   always #5 clk = ~clk;

   hog_svm_acc #(.NBLK(NBLK), .ACC_W(ACC_A)) u_dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .bid(bid),
      .fea_a(fea_a), .fea_b(fea_b), .fea_c(fea_c), .fea_d(fea_d), .bias(bias),
      .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data), .busy(busy), .overrun(overrun),
      .o_valid(o_valid), .o_bid(o_bid), .score(score), .detect(detect));

   hog_svm_acc #(.NBLK(NBLK), .ACC_W(ACC_B)) u_dut48 (
      .clk(clk), .rst(rst), .i_valid(i_valid), .bid(bid),
      .fea_a(fea_a), .fea_b(fea_b), .fea_c(fea_c), .fea_d(fea_d), .bias(bias48),
      .w_rd(w_rd48), .w_addr(w_addr48), .w_data(w_data), .busy(busy48), .overrun(overrun48),
      .o_valid(o_valid48), .o_bid(o_bid48), .score(score48), .detect(detect48));

   typedef struct {
      longint           score;
      logic             det;
      logic [BID_W-1:0] bid;
      int               cyc;
   } exp_t;

   exp_t        q56[$];
   exp_t        q48[$];
   int          qa[$];
   logic [63:0] wmem [0:17];
   logic [31:0] win_f [NBLK];
   bit          win_u [NBLK];
   int          blkm;
   int          cyc_cnt;
   int          n_vec;
   int          n_err;

   // One comparison: count it, report it on mismatch.
   task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic longint acc_step(input longint a, input longint b, input int w);
      longint one = 1;
      longint mx  = (one <<< (w - 1)) - 1;
      longint mn  = -mx - 1;
      longint r   = a + b;
      if (SAT) begin
         if (r > mx) return mx;
         if (r < mn) return mn;
         return r;
      end
      return (r <<< (64 - w)) >>> (64 - w);
   endfunction

   function automatic longint fval(input logic [31:0] f, input bit uni, input int c, input int k);
      if (uni) return longint'(f);
      return longint'(f) + longint'(c) * 64'sd16777216 + longint'(k) * 64'sd1048576;
   endfunction

   function automatic longint win_score(input int w, input longint bs);
      longint acc = 0;
      longint rs;
      logic [15:0] wv;
      for (int b = 0; b < int'(NBLK); b++) begin
         for (int k = 0; k < 9; k++) begin
            rs = 0;
            for (int c = 0; c < 4; c++) begin
               wv = wmem[b * 9 + k][c * 16 +: 16];
               rs += fval(win_f[b], win_u[b], c, k) * longint'($signed(wv));
            end
            acc = acc_step(acc, rs, w);
         end
      end
      return acc_step(acc, bs, w);
   endfunction

   always @(posedge clk) begin
      cyc_cnt <= cyc_cnt + 1;
      if (w_rd) w_data <= wmem[w_addr];
   end

   // Read-address monitor.
   always @(negedge clk) begin
      if (!rst && w_rd) begin
         if (qa.size() == 0) begin
            check("w_rd_unexpected", 1, 0);
         end else begin
            int ea;
            ea = qa.pop_front();
            check("w_addr", 64'(w_addr), 64'(ea));
            check("w_addr48", 64'(w_addr48), 64'(ea));
            check("w_rd48", 64'(w_rd48), 1);
         end
      end
   end

   // Score monitors.
   always @(negedge clk) begin
      if (!rst && o_valid) begin
         if (q56.size() == 0) begin
            check("o_valid_unexpected", 1, 0);
         end else begin
            exp_t e;
            e = q56.pop_front();
            check("score", score, e.score);
            check("detect", 64'(detect), 64'(e.det));
            check("o_bid", 64'(o_bid), 64'(e.bid));
            check("o_valid_cycle", 64'(cyc_cnt), 64'(e.cyc));
         end
      end
      if (!rst && o_valid48) begin
         if (q48.size() == 0) begin
            check("o_valid48_unexpected", 1, 0);
         end else begin
            exp_t e;
            e = q48.pop_front();
            check("score48", score48, e.score);
            check("detect48", 64'(detect48), 64'(e.det));
            check("o_bid48", 64'(o_bid48), 64'(e.bid));
            check("o_valid48_cycle", 64'(cyc_cnt), 64'(e.cyc));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_w(input logic [15:0] wa, input logic [15:0] wb, input logic [15:0] wc, input logic [15:0] wd);
      for (int i = 0; i < 18; i++) wmem[i] = {wd, wc, wb, wa};
   endtask

   // Drive one descriptor for one cycle; when it should be accepted, queue its addresses and, for the last block, the score.
   task automatic send(input logic [BID_W-1:0] b, input logic [31:0] f, input bit uni, input bit acc);
      logic [9*FEA_W-1:0] fx [4];
      int c0;
      exp_t e;
      for (int c = 0; c < 4; c++)
         for (int k = 0; k < 9; k++) fx[c][k * FEA_W +: FEA_W] = 32'(fval(f, uni, c, k));
      fea_a = fx[0]; fea_b = fx[1]; fea_c = fx[2]; fea_d = fx[3];
      bid = b;
      i_valid = 1'b1;
      c0 = cyc_cnt;
      if (acc) begin
         for (int k = 0; k < 9; k++) qa.push_back(blkm * 9 + k);
         win_f[blkm] = f;
         win_u[blkm] = uni;
         if (blkm == int'(NBLK) - 1) begin
            e.bid = b;
            e.cyc = c0 + 12;
            e.score = win_score(ACC_A, longint'(bias));
            e.det = (e.score > 0);
            q56.push_back(e);
            e.score = win_score(ACC_B, longint'(bias48));
            e.det = (e.score > 0);
            q48.push_back(e);
            blkm = 0;
         end else begin
            blkm++;
         end
      end
      tick(1);
      i_valid = 1'b0;
   endtask

   task automatic window(input logic [BID_W-1:0] b, input logic [31:0] f, input bit uni);
      send(b, f, uni, 1'b1);
      tick(11);
      send(b + 13'd1, f, uni, 1'b1);
      tick(13);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_w_rd"}, 64'(w_rd), 0);
      check({tag, "_w_addr"}, 64'(w_addr), 0);
      check({tag, "_busy"}, 64'(busy), 0);
      check({tag, "_overrun"}, 64'(overrun), 0);
      check({tag, "_o_valid"}, 64'(o_valid), 0);
      check({tag, "_o_bid"}, 64'(o_bid), 0);
      check({tag, "_score"}, score, 0);
      check({tag, "_detect"}, 64'(detect), 0);
      check({tag, "_busy48"}, 64'(busy48), 0);
      check({tag, "_overrun48"}, 64'(overrun48), 0);
   endtask

   initial begin
      n_vec = 0; n_err = 0; blkm = 0; cyc_cnt = 0;
      rst = 1'b1; i_valid = 1'b0; bid = '0;
      fea_a = '0; fea_b = '0; fea_c = '0; fea_d = '0;
      bias = '0; bias48 = '0; w_data = '0;
      set_w(16'h1000, 16'h1000, 16'h1000, 16'h1000);
      tick(3);
      @(negedge clk);
      check_zero("reset");
      tick(1);
      rst = 1'b0;
      tick(2);

      // 0.5 * 1.0 over 72 bins -> 36.0
      window(13'd10, 32'h0800_0000, 1'b1);
      // negative weights with positive and exactly-cancelling bias
      set_w(16'hF000, 16'hF000, 16'hF000, 16'hF000);
      bias = 56'sd40 <<< 40; bias48 = 48'sd40 <<< 40;
      window(13'd100, 32'h0800_0000, 1'b1);
      bias = 56'sd36 <<< 40; bias48 = 48'sd36 <<< 40;
      window(13'd200, 32'h0800_0000, 1'b1);

      // dropped descriptor while busy; per-cell/per-bin features and mixed weights
      check("overrun_before", 64'(overrun), 0);
      set_w(16'h1000, 16'h2000, 16'hF000, 16'h0800);
      bias = '0; bias48 = '0;
      send(13'd20, 32'h0400_0000, 1'b0, 1'b1);
      tick(4);
      send(13'd99, 32'hFFFF_FFFF, 1'b1, 1'b0);
      check("overrun_set", 64'(overrun), 1);
      check("busy_during", 64'(busy), 1);
      check("overrun48_set", 64'(overrun48), 1);
      tick(6);
      send(13'd21, 32'h0300_0000, 1'b0, 1'b1);
      tick(13);
      check("overrun_sticky", 64'(overrun), 1);

      // descriptor arriving in the OUT cycle is dropped; next one starts a new window
      send(13'd60, 32'h0200_0000, 1'b0, 1'b1);
      tick(11);
      send(13'd61, 32'h0100_0000, 1'b0, 1'b1);
      tick(11);
      check("busy_out", 64'(busy), 1);
      send(13'd62, 32'h0800_0000, 1'b1, 1'b0);
      check("busy_after_out", 64'(busy), 0);
      send(13'd63, 32'h0600_0000, 1'b0, 1'b1);
      tick(11);
      send(13'd64, 32'h0500_0000, 1'b0, 1'b1);
      tick(13);

      // reset in FETCH of the last block aborts the window
      set_w(16'h1000, 16'h1000, 16'h1000, 16'h1000);
      send(13'd30, 32'h0800_0000, 1'b1, 1'b1);
      tick(11);
      send(13'd31, 32'h0800_0000, 1'b1, 1'b1);
      tick(3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      qa.delete(); q56.delete(); q48.delete(); blkm = 0;
      @(negedge clk);
      check_zero("midrst");
      tick(1);
      rst = 1'b0;
      tick(2);
      window(13'd40, 32'h0800_0000, 1'b1);

      // accumulator range limit on the 48-bit instance
      set_w(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      bias = '0;
      bias48 = {1'b0, {(ACC_B-1){1'b1}}};
      window(13'd50, 32'h0800_0000, 1'b1);

      for (int i = 0; i < 100 && (q56.size() != 0 || q48.size() != 0 || qa.size() != 0); i++) tick(1);
      check("sb56_drained", 64'(q56.size()), 0);
      check("sb48_drained", 64'(q48.size()), 0);
      check("addr_drained", 64'(qa.size()), 0);
      check("idle_end", 64'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hog_svm_acc.md
Name: hog_svm_acc

Overview:
- Linear-SVM scoring stage directly downstream of the HOG feature generator.
- Consumes one normalized 36-element block descriptor (fea_a..fea_d, 9 bins each) per i_valid pulse.
- Multiplies each descriptor by per-block weights fetched from an external weight memory and accumulates NBLK consecutive blocks into one detection-window score.
- Adds a bias and emits score plus a detect flag once per window.

Parameters:
FEA_I, 4, integer bits of unsigned hog feature
FEA_F, 28, fraction bits of hog feature
W_W, 16, signed weight width (two's complement)
W_F, 12, fraction bits of weight
BID_W, 13, block id width
NBLK, 105, blocks per detection window
WA_W, 10, weight address width (must hold NBLK*9-1)
ACC_W, 56, signed accumulator/score width; fraction bits = FEA_F+W_F

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
i_valid  input  1  block descriptor valid (single-cycle pulse, no backpressure)
bid  input  BID_W  id of incoming block
fea_a  input  9*(FEA_I+FEA_F)  bins 0..8 of cell a, bin0 at LSB
fea_b  input  9*(FEA_I+FEA_F)  cell b, same packing
fea_c  input  9*(FEA_I+FEA_F)  cell c, same packing
fea_d  input  9*(FEA_I+FEA_F)  cell d, same packing
bias  input  ACC_W  signed bias, same format as accumulator, sampled at OUT
w_rd  output  1  weight read strobe
w_addr  output  WA_W  weight row address
w_data  input  4*W_W  weights for a,b,c,d (a at LSB); valid 1 cycle after w_rd
busy  output  1  block in progress; i_valid ignored while high
overrun  output  1  sticky: i_valid arrived while busy
o_valid  output  1  one-cycle score strobe
o_bid  output  BID_W  bid of last block of window
score  output  ACC_W  signed acc+bias
detect  output  1  score > 0 (strictly positive)

Behaviour:
- Reset: all outputs 0, state IDLE, acc 0, blk_cnt 0, overrun 0. Reset mid-operation aborts the block and window; no o_valid follows.
- States: IDLE, FETCH, DRAIN, OUT.
- IDLE: on i_valid, latch features and bid. If blk_cnt==0, clear acc. Go to FETCH, k=0. busy=1 from next cycle.
- FETCH: 9 cycles, k=0..8. w_rd=1, w_addr=blk_cnt*9+k. On k==8, go to DRAIN.
- Pipeline:
  - w_data for row k returns one cycle after its w_rd.
  - Next cycle, register four products: fea_x[bin k] * w_x. Feature zero-extended to signed; full-width products.
  - Next cycle, add the sum of the four products, sign-extended to ACC_W, into acc.
- DRAIN: 2 cycles, flushing the last products.
  - If blk_cnt==NBLK-1: go to OUT.
  - Otherwise: blk_cnt++, go to IDLE.
- OUT: 1 cycle.
  - o_valid=1; score=acc+bias; detect=(score>0); o_bid=latched bid.
  - blk_cnt=0, go to IDLE.
- Timing, with i_valid at cycle 0:
  - w_rd on cycles 1–9; accumulation on cycles 3–11.
  - busy high on cycles 1–11 (non-last block) or 1–12 (last block).
  - Next block accepted at cycle 12 (non-last) or cycle 13 (last block). Last-block o_valid at cycle 12.
- score, detect and o_bid hold their value until the next OUT. o_valid is low otherwise.
- i_valid while busy: block dropped, overrun set (sticky until rst), no state change.
- i_valid in the same cycle as OUT: treated as busy (dropped, overrun).
- Without the optional feature, arithmetic wraps modulo 2^ACC_W.

Optional Feature:
- Macro HOG_SVM_SAT_EN.
- Defined: acc update and the bias add both saturate to signed ACC_W limits: max 2^(ACC_W-1)-1, min -2^(ACC_W-1).
- Undefined: both wrap two's complement. No extra logic.

Test Plan:
1. NBLK=2; all features 0x0800_0000 (0.5), all weights 0x1000 (1.0), bias 0; two i_valid 12 cycles apart -> o_valid 12 cycles after the second; score = 36<<40 (36.0); detect=1.
2. As test 1 but weights 0xF000 (-1.0), bias = 40<<40 -> score = 4<<40; detect=1. Repeat with bias = 36<<40 -> score 0, detect=0.
3. NBLK=2, second block -> w_addr sequence 9..17 on consecutive cycles with w_rd=1; first block shows 0..8.
4. i_valid again 5 cycles after an accepted one -> overrun=1; w_addr sequence unaffected; blk_cnt unchanged; window completes after one more valid block.
5. rst asserted during FETCH of the last block -> all outputs 0 next cycle, no o_valid; a fresh window then scores as in test 1.
6. ACC_W=48, features 0x0800_0000, weights 0x7FFF, bias = 2^47-1 -> with HOG_SVM_SAT_EN: score = 2^47-1, detect=1; without: wrapped value, negative, detect=0.
